// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Brief    : Shared types and constants for the instruction fetch unit.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

    // Canonical RISC-V NOP (addi x0, x0, 0), shown when the buffer is empty
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One fetched instruction together with the PC it was fetched from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Fetch control states: one idle boot cycle, then continuous fetch
    typedef enum logic [0:0] {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit_if
//  Brief    : Bundles the instruction-memory port, the decode handshake,
//             the control redirect inputs and the perf counters.
//             master = fetch unit side, slave = environment side.
//  Revision : 1.0  initial release
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int IMEM_AW = 5
);
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               instr_valid;
    logic               instr_ready;
    logic [31:0]        instr;
    logic [31:0]        instr_pc;
    logic               branch_taken;
    logic [31:0]        branch_target;
    logic               jump;
    logic [31:0]        jump_target;
    logic [31:0]        perf_fetch_cnt;
    logic [31:0]        perf_flush_cnt;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        output instr_valid, instr, instr_pc,
        input  instr_ready,
        input  branch_taken, branch_target, jump, jump_target,
        output perf_fetch_cnt, perf_flush_cnt
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        input  instr_valid, instr, instr_pc,
        output instr_ready,
        output branch_taken, branch_target, jump, jump_target,
        input  perf_fetch_cnt, perf_flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_buffer
//  Brief    : Small FIFO of fetch entries with push/pop/flush. Flush beats a
//             simultaneous push; pop on empty and push on full are ignored.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        push,
    input  wire fetch_entry_t                push_entry,
    input  wire logic                        pop,
    input  wire logic                        flush,
    output fetch_entry_t                     head,
    output logic [$clog2(FIFO_DEPTH):0]      count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t     r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && (r_count != CW'(FIFO_DEPTH));
    assign w_do_pop  = pop && (r_count != '0);

    // Entry storage; stale data behind the pointers is harmless
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= push_entry;
        end
    end

    // Pointer and occupancy tracking; reset and flush both empty the FIFO
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Brief    : Fetch stage. Owns the PC, issues word reads to a 1-cycle
//             synchronous instruction memory under a credit rule, buffers
//             responses and hands {instr, pc} to decode. Redirects flush the
//             buffer and kill the in-flight response.
//             Optional macro FETCH_PERF_EN adds delivered/redirect counters.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          IMEM_AW    = 5,
    parameter int          FIFO_DEPTH = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    instr_fetch_unit_if.master  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t   r_state;
    fetch_state_t   w_state_nxt;
    logic [31:0]    r_pc;
    logic [31:0]    r_req_pc;
    logic           r_inflight;
    logic           w_issue;
    logic           w_redirect;
    logic [31:0]    w_target;
    logic           w_push;
    logic           w_pop;
    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_used;
    fetch_entry_t   w_head;
    fetch_entry_t   w_push_entry;

    // Jump outranks a taken branch; targets are forced word aligned
    assign w_redirect = bus.jump | bus.branch_taken;
    assign w_target   = (bus.jump ? bus.jump_target : bus.branch_target) & ~32'h3;

    // Buffer slots already spoken for, including the response on its way
    assign w_used = w_count + CW'(r_inflight);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and issue decision
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_issue = !w_redirect && (w_used < CW'(FIFO_DEPTH));
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    // PC, request PC and in-flight tracking; a redirect clears the in-flight
    // flag because no request goes out in that cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc       <= PC_RESET;
            r_req_pc   <= PC_RESET;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_redirect) begin
                r_pc <= w_target;
            end else if (w_issue) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + 32'd4;
            end
        end
    end

    // A response arriving in a redirect cycle belongs to the wrong path
    assign w_push             = r_inflight && !w_redirect;
    assign w_pop              = (w_count != '0) && bus.instr_ready;
    assign w_push_entry.pc    = r_req_pc;
    assign w_push_entry.instr = bus.imem_rdata;

    fetch_buffer #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fetch_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .flush      (w_redirect),
        .head       (w_head),
        .count      (w_count)
    );

    assign bus.imem_req    = w_issue;
    assign bus.imem_addr   = r_pc[IMEM_AW+1:2];
    assign bus.instr_valid = (w_count != '0);
    assign bus.instr       = (w_count != '0) ? w_head.instr : NOP_INSTR;
    assign bus.instr_pc    = (w_count != '0) ? w_head.pc    : 32'h0;

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;

    // Delivered-instruction and redirect counters, free-running with wrap
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_redirect) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign bus.perf_fetch_cnt = r_fetch_cnt;
    assign bus.perf_flush_cnt = r_flush_cnt;
`else
    assign bus.perf_fetch_cnt = 32'h0;
    assign bus.perf_flush_cnt = 32'h0;
`endif

endmodule
`default_nettype wire
